// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for clock_divider_prog; the master drives enable and loads, the slave reports state.
// CLKDIV_DUTY_EN adds high_cnt/cur_high for a programmable high time.
interface clock_divider_prog_if #(
  parameter int DIV_WIDTH = 8
);
  logic                 en;
  logic [DIV_WIDTH-1:0] div;
  logic                 div_load;
  logic                 div_busy;
  logic [DIV_WIDTH-1:0] cur_div;
  logic                 clk_out;
  logic                 period_start;
`ifdef CLKDIV_DUTY_EN
  logic [DIV_WIDTH-1:0] high_cnt;
  logic [DIV_WIDTH-1:0] cur_high;

  modport master (
    output en, div, div_load, high_cnt,
    input  div_busy, cur_div, clk_out, period_start, cur_high
  );
  modport slave (
    input  en, div, div_load, high_cnt,
    output div_busy, cur_div, clk_out, period_start, cur_high
  );
`else
  modport master (
    output en, div, div_load,
    input  div_busy, cur_div, clk_out, period_start
  );
  modport slave (
    input  en, div, div_load,
    output div_busy, cur_div, clk_out, period_start
  );
`endif
endinterface

// File: rtl/clock_divider_prog.sv
// Programmable posedge clock divider; all outputs registered, divisor changes land only on a period wrap.
// Loads handshake through div_busy (loads ignored while busy); CLKDIV_DUTY_EN enables programmable high time.
module clock_divider_prog #(
  parameter int   DIV_WIDTH   = 8,
  parameter int   DIV_DEFAULT = 2,
  parameter logic OUT_INIT    = 1'b1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  clock_divider_prog_if.slave  bus
);

  localparam int DIV_MAX   = (1 << DIV_WIDTH) - 1;
  localparam int DEF_CLAMP = (DIV_DEFAULT < 2) ? 2 :
                             ((DIV_DEFAULT > DIV_MAX) ? DIV_MAX : DIV_DEFAULT);
  localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(DEF_CLAMP);
  localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO      = DIV_WIDTH'(2);

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] v);
    return (v < TWO) ? TWO : v;
  endfunction

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] cur_div_q, cur_div_d;
  logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
  logic                 div_busy_q, div_busy_d;
  logic                 period_start_q, period_start_d;
  logic                 clk_out_q, clk_out_d;
  logic [DIV_WIDTH:0]   high_nxt;
  logic                 wrap;

`ifdef CLKDIV_DUTY_EN
  localparam logic [DIV_WIDTH-1:0] HIGH_RST = DIV_WIDTH'((DEF_CLAMP + 1) / 2);

  // High time must leave at least one cycle in each phase.
  function automatic logic [DIV_WIDTH-1:0] clamp_high(input logic [DIV_WIDTH-1:0] h,
                                                      input logic [DIV_WIDTH-1:0] d);
    if (h == '0)
      return ONE;
    else if (h >= d)
      return d - ONE;
    else
      return h;
  endfunction

  logic [DIV_WIDTH-1:0] cur_high_q, cur_high_d;
  logic [DIV_WIDTH-1:0] pend_high_q, pend_high_d;
`endif

  assign wrap = (cnt_q == (cur_div_q - ONE));

  always_comb begin
    cnt_d          = cnt_q;
    cur_div_d      = cur_div_q;
    pend_div_d     = pend_div_q;
    div_busy_d     = div_busy_q;
    period_start_d = 1'b0;
`ifdef CLKDIV_DUTY_EN
    cur_high_d     = cur_high_q;
    pend_high_d    = pend_high_q;
`endif
    if (bus.en) begin
      if (wrap) begin
        cnt_d          = '0;
        period_start_d = 1'b1;
        if (div_busy_q) begin
          cur_div_d  = pend_div_q;
          div_busy_d = 1'b0;
`ifdef CLKDIV_DUTY_EN
          cur_high_d = pend_high_q;
`endif
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
    // Uses the old busy flag, so a load coinciding with a wrap waits for the next one.
    if (bus.div_load && !div_busy_q) begin
      pend_div_d  = clamp_div(bus.div);
      div_busy_d  = 1'b1;
`ifdef CLKDIV_DUTY_EN
      pend_high_d = clamp_high(bus.high_cnt, clamp_div(bus.div));
`endif
    end
`ifdef CLKDIV_DUTY_EN
    high_nxt = {1'b0, cur_high_d};
`else
    high_nxt = ({1'b0, cur_div_d} + {{DIV_WIDTH{1'b0}}, 1'b1}) >> 1;
`endif
    clk_out_d = ({1'b0, cnt_d} < high_nxt) ? OUT_INIT : ~OUT_INIT;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q          <= '0;
      cur_div_q      <= DIV_RST;
      pend_div_q     <= DIV_RST;
      div_busy_q     <= 1'b0;
      period_start_q <= 1'b0;
      clk_out_q      <= OUT_INIT;
`ifdef CLKDIV_DUTY_EN
      cur_high_q     <= HIGH_RST;
      pend_high_q    <= HIGH_RST;
`endif
    end else begin
      cnt_q          <= cnt_d;
      cur_div_q      <= cur_div_d;
      pend_div_q     <= pend_div_d;
      div_busy_q     <= div_busy_d;
      period_start_q <= period_start_d;
      clk_out_q      <= clk_out_d;
`ifdef CLKDIV_DUTY_EN
      cur_high_q     <= cur_high_d;
      pend_high_q    <= pend_high_d;
`endif
    end
  end

  assign bus.div_busy     = div_busy_q;
  assign bus.cur_div      = cur_div_q;
  assign bus.clk_out      = clk_out_q;
  assign bus.period_start = period_start_q;
`ifdef CLKDIV_DUTY_EN
  assign bus.cur_high     = cur_high_q;
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: period-position model checked every cycle plus directed literal checks.
// Exercises the duty-cycle feature when CLKDIV_DUTY_EN is defined.
module tb_clock_divider_prog;
  localparam int W = 8;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  clock_divider_prog_if #(.DIV_WIDTH(W)) bus ();

  clock_divider_prog #(
    .DIV_WIDTH  (W),
    .DIV_DEFAULT(4),
    .OUT_INIT   (1'b1)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampd(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic int clamph(input int h, input int d);
    return (h < 1) ? 1 : ((h > d - 1) ? d - 1 : h);
  endfunction

  // Model: position within the current period, period length, high time, pending load.
  int m_pos, m_D, m_H, m_pD, m_pH, m_busy, m_ps;

  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      m_pos = 0; m_D = 4; m_H = 2; m_pD = 4; m_pH = 2; m_busy = 0; m_ps = 0;
    end else begin
      int busy_was;
      busy_was = m_busy;
      m_ps = 0;
      if (bus.en) begin
        if (m_pos == m_D - 1) begin
          m_pos = 0;
          m_ps  = 1;
          if (busy_was != 0) begin
            m_D = m_pD; m_H = m_pH; m_busy = 0;
          end
        end else begin
          m_pos = m_pos + 1;
        end
      end
      if (bus.div_load && busy_was == 0) begin
        m_pD = clampd(int'(bus.div));
`ifdef CLKDIV_DUTY_EN
        m_pH = clamph(int'(bus.high_cnt), m_pD);
`else
        m_pH = (m_pD + 1) / 2;
`endif
        m_busy = 1;
      end
    end
  end

  always @(negedge clk_in) begin
    if (chk_on && !reset) begin
      check("m_clk_out", bus.clk_out, (m_pos < m_H) ? 1 : 0);
      check("m_period_start", bus.period_start, m_ps);
      check("m_div_busy", bus.div_busy, m_busy);
      check("m_cur_div", bus.cur_div, m_D);
`ifdef CLKDIV_DUTY_EN
      check("m_cur_high", bus.cur_high, m_H);
`endif
    end
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic load_h(input int v, input int h);
    bus.div = v[W-1:0];
`ifdef CLKDIV_DUTY_EN
    bus.high_cnt = h[W-1:0];
`endif
    bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
  endtask

  task automatic load(input int v);
    load_h(v, (clampd(v) + 1) / 2);
  endtask

  task automatic wait_wrap(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.period_start !== 1'b1 && n < 300);
    if (n >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_wrap: no period_start within %0d cycles", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic pat4[8];
    logic pat5[5];
    logic pat2[4];
    pat4 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    pat5 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    pat2 = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.en = 1'b0;
    bus.div = '0;
    bus.div_load = 1'b0;
`ifdef CLKDIV_DUTY_EN
    bus.high_cnt = '0;
`endif
    repeat (2) tick();
    check("rst_clk_out", bus.clk_out, 1);
    check("rst_period_start", bus.period_start, 0);
    check("rst_div_busy", bus.div_busy, 0);
    check("rst_cur_div", bus.cur_div, 4);

    reset = 1'b0;
    bus.en = 1'b1;
    chk_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("d4_clk_out", bus.clk_out, pat4[i]);
      check("d4_period_start", bus.period_start, (i == 4) ? 1 : 0);
      tick();
    end

    // Load 5 at the start of a D=4 period.
    load(5);
    check("ld5_busy", bus.div_busy, 1);
    wait_wrap(n);
    check("ld5_wrap_delay", n, 3);
    check("ld5_cur_div", bus.cur_div, 5);
    check("ld5_busy_clear", bus.div_busy, 0);
    for (int i = 0; i < 5; i++) begin
      check("d5_clk_out", bus.clk_out, pat5[i]);
      tick();
    end

    // Back to D=4, then load 6 at cnt=1 and a second load of 9 while busy.
    load(4);
    wait_wrap(n);
    check("ld4_cur_div", bus.cur_div, 4);
    tick();
    bus.div = 8'd6;
    bus.div_load = 1'b1;
    tick();
    bus.div = 8'd9;
    tick();
    bus.div_load = 1'b0;
    check("ld6_busy", bus.div_busy, 1);
    wait_wrap(n);
    check("d4_period_intact", n, 1);
    check("ld6_cur_div", bus.cur_div, 6);
    wait_wrap(n);
    check("d6_period_len", n, 6);
    wait_wrap(n);
    check("d6_period_len2", n, 6);
    check("ld9_ignored", bus.cur_div, 6);

    // Divisors below 2 clamp to 2.
    load(0);
    check("ld0_busy", bus.div_busy, 1);
    wait_wrap(n);
    check("ld0_wrap_delay", n, 5);
    check("ld0_cur_div", bus.cur_div, 2);
    for (int i = 0; i < 4; i++) begin
      check("d2_clk_out", bus.clk_out, pat2[i]);
      tick();
    end
    load(1);
    check("ld1_busy", bus.div_busy, 1);
    wait_wrap(n);
    check("ld1_wrap_delay", n, 1);
    check("ld1_cur_div", bus.cur_div, 2);
    check("ld1_busy_clear", bus.div_busy, 0);

    // Freeze with a pending load.
    load(7);
    wait_wrap(n);
    check("ld7_cur_div", bus.cur_div, 7);
    tick();
    tick();
    load(3);
    bus.en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("frz_clk_out", bus.clk_out, 1);
      check("frz_period_start", bus.period_start, 0);
      check("frz_busy", bus.div_busy, 1);
    end
    bus.en = 1'b1;
    wait_wrap(n);
    check("frz_resume_wrap", n, 4);
    check("frz_cur_div", bus.cur_div, 3);

    // Reset mid-period with a pending load.
    load(9);
    tick();
    check("pre_rst_clk_out", bus.clk_out, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_clk_out", bus.clk_out, 1);
    check("mid_rst_cur_div", bus.cur_div, 4);
    check("mid_rst_busy", bus.div_busy, 0);
    check("mid_rst_period_start", bus.period_start, 0);
    tick();
    reset = 1'b0;
    wait_wrap(n);
    check("post_rst_first_wrap", n, 4);
    check("post_rst_cur_div", bus.cur_div, 4);
    wait_wrap(n);
    check("post_rst_second_wrap", n, 4);
    check("post_rst_lost_load", bus.cur_div, 4);

`ifdef CLKDIV_DUTY_EN
    load_h(8, 2);
    wait_wrap(n);
    check("duty_cur_div", bus.cur_div, 8);
    check("duty_cur_high2", bus.cur_high, 2);
    for (int i = 0; i < 8; i++) begin
      check("duty_h2_clk_out", bus.clk_out, (i < 2) ? 1 : 0);
      tick();
    end
    load_h(8, 0);
    wait_wrap(n);
    check("duty_cur_high0", bus.cur_high, 1);
    for (int i = 0; i < 8; i++) begin
      check("duty_h0_clk_out", bus.clk_out, (i < 1) ? 1 : 0);
      tick();
    end
    load_h(8, 20);
    wait_wrap(n);
    check("duty_cur_high_max", bus.cur_high, 7);
`endif

    repeat (3) tick();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
